debug_sel_ctrl: RTL and testbench
=================================

DEBUG_SEL_CTRL -- requirements
Module: debug_sel_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, giving the number of stable synchronized samples (10 ms at 50 MHz) needed to accept a key level change.
REQ-002 SHALL have parameter SCROLL_CYCLES, default 50000000, giving the auto-scroll period in clocks (1 s at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port key_next, input, 1 bit: raw, asynchronous, active-low pushbutton; advances the bus index.
REQ-006 SHALL have port key_prev, input, 1 bit: raw, asynchronous, active-low pushbutton; steps the bus index back.
REQ-007 SHALL have port key_stage, input, 1 bit: raw, asynchronous, active-low pushbutton; advances the stage and keeps the bus index.
REQ-008 SHALL have port sw_auto, input, 1 bit: raw, asynchronous slide switch; high enables auto-scroll.
REQ-009 SHALL have port selm, output, 6 bits: registered display select; [5:3] is the stage (s1..s8) and [2:0] is the bus (b1..b8); feeds the display mux.
REQ-010 SHALL have port stage_led, output, 8 bits: one-hot decode of selm[5:3]; bit n is high when the stage is n.
REQ-011 SHALL have port step_pulse, output, 1 bit: registered; high for exactly the one cycle in which a new selm value first appears.

Function
REQ-012 SHALL pass each of key_next, key_prev, key_stage and sw_auto through its own 2-flop synchronizer before any other use.
REQ-013 SHALL keep one debounced level and one counter per key; the counter increments while the synchronized level differs from the debounced level and clears to 0 otherwise.
REQ-014 SHALL update the debounced level and clear the counter when the counter reaches DEB_CYCLES-1 with the difference still present; any bounce before that restarts the count.
REQ-015 SHALL produce a press event as a one-cycle internal strobe on a debounced 1->0 transition only; releases produce no event and a held key produces only one event.
REQ-016 SHALL advance selm to (selm+8) mod 64 on a stage event; this has the highest priority and any next/prev event in the same cycle is discarded.
REQ-017 SHALL, with no stage event, set selm to (selm+1) mod 64 on a next event alone; 63 wraps to 0.
REQ-018 SHALL, with no stage event, set selm to (selm-1) mod 64 on a prev event alone; 0 wraps to 63.
REQ-019 SHALL leave selm unchanged and keep step_pulse low when next and prev events occur in the same cycle without a stage event.
REQ-020 SHALL, while synchronized sw_auto is 1, run a prescaler 0..SCROLL_CYCLES-1; at terminal count it wraps to 0 and issues a tick that sets selm to (selm+1) mod 64.
REQ-021 SHALL hold the prescaler at 0 and issue no ticks while synchronized sw_auto is 0; re-enabling starts a full period from 0.
REQ-022 SHALL let any accepted key event (REQ-016..018) clear the prescaler to 0; a tick in the same cycle is discarded and the key action applies alone.
REQ-023 SHALL register selm and step_pulse together, so step_pulse is high in the first cycle the new selm is visible; stage_led is a combinational decode of registered selm.
REQ-024 SHALL update selm exactly DEB_CYCLES+3 rising edges after the first edge that samples a clean raw press low (2 synchronizer edges, DEB_CYCLES count edges, 1 output register edge).

Reset
REQ-025 SHALL, on any clock edge with rst=1, set selm=0, stage_led=8'b0000_0001 and step_pulse=0.
REQ-026 SHALL, on the same reset edge, set synchronizer flops and debounced levels of the keys to 1 (released), the sw_auto synchronizer to 0, and all counters to 0.
REQ-027 SHALL abort any in-progress debounce or scroll period when reset is asserted mid-operation, and SHALL generate no event from a key still held at reset release until it is released and pressed again.

Verification
REQ-028 SHALL pass the test: DEB_CYCLES=4, clean key_next press from reset -> selm 0->1 exactly 7 edges after the first low sample, step_pulse high 1 cycle, stage_led=0x01.
REQ-029 SHALL pass the test: key_next bouncing 0/1 every 2 cycles for 20 cycles, then released -> selm unchanged, step_pulse never high.
REQ-030 SHALL pass the test: selm=63, press next -> selm=0; then press prev -> selm=63; then press stage -> selm=7 (wrap), stage_led=0x01.
REQ-031 SHALL pass the test: selm=10, next and prev events on the same cycle -> selm stays 10; next, prev and stage on the same cycle -> selm=18, stage_led=0x04.
REQ-032 SHALL pass the test: SCROLL_CYCLES=10, sw_auto=1 from selm=0 -> selm increments every 10 cycles; a key event coinciding with a tick gives a single +1 and the next tick follows 10 cycles later.
REQ-033 SHALL pass the test: rst pulsed mid-debounce while key_prev is held low -> selm=0 after reset, with no event until the key is released and pressed again.

Source files
------------

// File: rtl/debug_sel_ctrl.sv
// Debug display selector: three debounced pushbuttons and an auto-scroll switch
// step a 6-bit stage/bus select used by the display mux.
module debug_sel_ctrl #(
    parameter int DEB_CYCLES    = 500000,
    parameter int SCROLL_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_next,
    input  logic       key_prev,
    input  logic       key_stage,
    input  logic       sw_auto,
    output logic [5:0] selm,
    output logic [7:0] stage_led,
    output logic       step_pulse
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_CYCLES - 1);

    // Key index: 0 = next, 1 = prev, 2 = stage
    logic [2:0]    key_raw_s;
    logic [2:0]    key_meta_r;
    logic [2:0]    key_sync_r;
    logic [2:0]    key_db_r;
    logic [2:0]    key_armed_r;
    logic [2:0]    key_press_r;
    logic [DW-1:0] key_cnt_r [3];
    logic          auto_meta_r;
    logic          auto_sync_r;
    logic [1:0]    sync_vld_r;
    logic [SW-1:0] pre_r;
    logic [SW-1:0] pre_nxt_s;
    logic [5:0]    selm_r;
    logic [5:0]    selm_nxt_s;
    logic          step_r;
    logic          key_any_s;
    logic          tick_s;

    assign key_raw_s = {key_stage, key_prev, key_next};

    // Two-flop synchronizers; sync_vld_r marks when they hold post-reset samples
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_r  <= 3'b111;
            key_sync_r  <= 3'b111;
            auto_meta_r <= 1'b0;
            auto_sync_r <= 1'b0;
            sync_vld_r  <= 2'b00;
        end else begin
            key_meta_r  <= key_raw_s;
            key_sync_r  <= key_meta_r;
            auto_meta_r <= sw_auto;
            auto_sync_r <= auto_meta_r;
            sync_vld_r  <= {sync_vld_r[0], 1'b1};
        end
    end

    // Debounce counters and press strobes; a key held through reset stays
    // disarmed until it has been seen released
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                key_cnt_r[k] <= '0;
            end
            key_db_r    <= 3'b111;
            key_armed_r <= 3'b000;
            key_press_r <= 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                key_press_r[k] <= 1'b0;
                if (sync_vld_r[1] && key_sync_r[k]) begin
                    key_armed_r[k] <= 1'b1;
                end else begin
                    key_armed_r[k] <= key_armed_r[k];
                end
                if (key_sync_r[k] != key_db_r[k]) begin
                    if (key_cnt_r[k] == DEB_LAST) begin
                        key_db_r[k]    <= key_sync_r[k];
                        key_cnt_r[k]   <= '0;
                        key_press_r[k] <= ~key_sync_r[k] & key_armed_r[k];
                    end else begin
                        key_cnt_r[k] <= key_cnt_r[k] + DW'(1);
                    end
                end else begin
                    key_cnt_r[k] <= '0;
                end
            end
        end
    end

    // Prescaler and select next-state; stage beats next/prev, keys beat the tick
    always_comb begin
        pre_nxt_s  = pre_r;
        selm_nxt_s = selm_r;
        tick_s     = 1'b0;
        key_any_s  = |key_press_r;
        if (!auto_sync_r || key_any_s) begin
            pre_nxt_s = '0;
        end else if (pre_r == SCROLL_LAST) begin
            pre_nxt_s = '0;
            tick_s    = 1'b1;
        end else begin
            pre_nxt_s = pre_r + SW'(1);
        end
        if (key_press_r[2]) begin
            selm_nxt_s = selm_r + 6'd8;
        end else if (key_press_r[0] && !key_press_r[1]) begin
            selm_nxt_s = selm_r + 6'd1;
        end else if (key_press_r[1] && !key_press_r[0]) begin
            selm_nxt_s = selm_r - 6'd1;
        end else if (tick_s) begin
            selm_nxt_s = selm_r + 6'd1;
        end else begin
            selm_nxt_s = selm_r;
        end
    end

    // Output registers: step pulse coincides with the first cycle of a new select
    always_ff @(posedge clk) begin
        if (rst) begin
            selm_r <= 6'd0;
            step_r <= 1'b0;
            pre_r  <= '0;
        end else begin
            selm_r <= selm_nxt_s;
            step_r <= (selm_nxt_s != selm_r);
            pre_r  <= pre_nxt_s;
        end
    end

    // One-hot stage decode of the registered select
    always_comb begin
        case (selm_r[5:3])
            3'd0:    stage_led = 8'b0000_0001;
            3'd1:    stage_led = 8'b0000_0010;
            3'd2:    stage_led = 8'b0000_0100;
            3'd3:    stage_led = 8'b0000_1000;
            3'd4:    stage_led = 8'b0001_0000;
            3'd5:    stage_led = 8'b0010_0000;
            3'd6:    stage_led = 8'b0100_0000;
            3'd7:    stage_led = 8'b1000_0000;
            default: stage_led = 8'b0000_0001;
        endcase
    end

    assign selm       = selm_r;
    assign step_pulse = step_r;

endmodule

// File: tb/tb_debug_sel_ctrl.sv
// Self-checking bench for debug_sel_ctrl: sample-history reference model compared
// every cycle, plus directed scenarios with hand-computed select values.
module tb_debug_sel_ctrl;

    localparam int DEB = 4;
    localparam int SC  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_next = 1'b1;
    logic       key_prev = 1'b1;
    logic       key_stage = 1'b1;
    logic       sw_auto = 1'b0;
    logic [5:0] selm;
    logic [7:0] stage_led;
    logic       step_pulse;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;

    debug_sel_ctrl #(.DEB_CYCLES(DEB), .SCROLL_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .key_next(key_next), .key_prev(key_prev),
        .key_stage(key_stage), .sw_auto(sw_auto), .selm(selm),
        .stage_led(stage_led), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    // Reference model over raw-sample history. Keys: 0 next, 1 prev, 2 stage; 3 = sw_auto.
    // A key level is accepted when the DEB samples taken 2..DEB+1 edges ago all differ
    // from it (and DEB edges have passed since the last acceptance); a press acts on the
    // following edge if the key was seen released since reset.
    bit       samp [4][0:4095];
    int       n = 2;
    int       rst_edge = 0;
    int       last_upd [3];
    bit       lvl [3];
    bit       seen_high [3];
    bit       ev_pend [3];
    bit       ev_now [3];
    bit       raw [4];
    int       pre_m = 0;
    logic [5:0] exp_selm = 6'd0;
    bit       exp_pulse = 1'b0;
    bit       model_valid = 1'b0;

    always @(posedge clk) begin
        bit all_diff, a_s, tick, key_any;
        logic [5:0] nxt;
        n = n + 1;
        raw[0] = key_next; raw[1] = key_prev; raw[2] = key_stage; raw[3] = sw_auto;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                samp[k][n]   = (k < 3);
                samp[k][n-1] = (k < 3);
            end
            for (int k = 0; k < 3; k++) begin
                lvl[k] = 1'b1; last_upd[k] = n; seen_high[k] = 1'b0; ev_pend[k] = 1'b0;
            end
            rst_edge = n; pre_m = 0; exp_selm = 6'd0; exp_pulse = 1'b0; model_valid = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) samp[k][n] = raw[k];
            for (int k = 0; k < 3; k++) begin
                ev_now[k] = ev_pend[k];
                ev_pend[k] = 1'b0;
                if (n - 2 >= rst_edge + 1 && samp[k][n-2]) seen_high[k] = 1'b1;
                if (n - last_upd[k] >= DEB) begin
                    all_diff = 1'b1;
                    for (int j = n - DEB - 1; j <= n - 2; j++)
                        if (samp[k][j] == lvl[k]) all_diff = 1'b0;
                    if (all_diff) begin
                        lvl[k] = ~lvl[k];
                        last_upd[k] = n;
                        if (!lvl[k] && seen_high[k]) ev_pend[k] = 1'b1;
                    end
                end
            end
            a_s = samp[3][n-2];
            key_any = ev_now[0] | ev_now[1] | ev_now[2];
            tick = 1'b0;
            if (!a_s || key_any) pre_m = 0;
            else if (pre_m == SC - 1) begin pre_m = 0; tick = 1'b1; end
            else pre_m = pre_m + 1;
            nxt = exp_selm;
            if (ev_now[2]) nxt = exp_selm + 6'd8;
            else if (ev_now[0] && !ev_now[1]) nxt = exp_selm + 6'd1;
            else if (ev_now[1] && !ev_now[0]) nxt = exp_selm - 6'd1;
            else if (!key_any && tick) nxt = exp_selm + 6'd1;
            exp_pulse = (nxt != exp_selm);
            exp_selm = nxt;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (selm !== exp_selm || step_pulse !== exp_pulse ||
                stage_led !== (8'd1 << exp_selm[5:3])) begin
                failures++;
                $display("FAIL model_cmp t=%0t selm=%0d exp=%0d pulse=%0b exp=%0b led=%0h",
                         $time, selm, exp_selm, step_pulse, exp_pulse, stage_led);
            end
        end
        if (step_pulse === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic press(input bit pn, input bit pp, input bit ps);
        key_next = ~pn; key_prev = ~pp; key_stage = ~ps;
        repeat (10) @(negedge clk);
        key_next = 1'b1; key_prev = 1'b1; key_stage = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int p0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_selm", selm, 0);
        chk("reset_led", stage_led, 8'h01);
        chk("reset_pulse", step_pulse, 0);

        // Clean press: select changes on the 7th edge after the first low sample
        key_next = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("latency_before", selm, 0);
        @(posedge clk);
        #1 chk("latency_selm", selm, 1);
        chk("latency_pulse", step_pulse, 1);
        chk("latency_led", stage_led, 8'h01);
        @(posedge clk);
        #1 chk("pulse_one_cycle", step_pulse, 0);
        repeat (4) @(negedge clk);
        key_next = 1'b1;
        repeat (10) @(negedge clk);

        // Bounce shorter than the debounce window
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            key_next = 1'b0; repeat (2) @(negedge clk);
            key_next = 1'b1; repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("bounce_selm", selm, 1);
        chk("bounce_pulses", pulse_cnt - p0, 0);

        // Wrap-around in both directions and stage wrap
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("prev_wrap_63", selm, 63);
        press(1'b1, 1'b0, 1'b0);
        chk("next_wrap_0", selm, 0);
        press(1'b0, 1'b1, 1'b0);
        chk("prev_wrap_63b", selm, 63);
        press(1'b0, 1'b0, 1'b1);
        chk("stage_wrap", selm, 7);
        chk("stage_wrap_led", stage_led, 8'h01);

        // Simultaneous events
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("reach_10", selm, 10);
        p0 = pulse_cnt;
        press(1'b1, 1'b1, 1'b0);
        chk("next_prev_cancel", selm, 10);
        chk("next_prev_no_pulse", pulse_cnt - p0, 0);
        press(1'b1, 1'b1, 1'b1);
        chk("stage_priority", selm, 18);
        chk("stage_priority_led", stage_led, 8'h04);

        // Auto-scroll every SC cycles; a key event on a tick edge gives one step
        do_reset();
        sw_auto = 1'b1;
        repeat (11) @(posedge clk);
        #1 chk("auto_before_tick", selm, 0);
        @(posedge clk);
        #1 chk("auto_tick1", selm, 1);
        chk("auto_tick1_pulse", step_pulse, 1);
        repeat (10) @(posedge clk);
        #1 chk("auto_tick2", selm, 2);
        repeat (4) @(negedge clk);
        key_next = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("coincide_before", selm, 2);
        @(posedge clk);
        #1 chk("coincide_single_step", selm, 3);
        repeat (9) @(posedge clk);
        #1 chk("after_coincide_wait", selm, 3);
        @(posedge clk);
        #1 chk("after_coincide_tick", selm, 4);
        @(negedge clk);
        sw_auto = 1'b0;
        key_next = 1'b1;
        repeat (15) @(negedge clk);

        // Reset mid-debounce with key_prev held through reset
        key_prev = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_through_reset", selm, 0);
        key_prev = 1'b1;
        repeat (10) @(negedge clk);
        key_prev = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("repress_before", selm, 0);
        @(posedge clk);
        #1 chk("repress_selm", selm, 63);
        chk("repress_pulse", step_pulse, 1);
        @(negedge clk);
        key_prev = 1'b1;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
